// File: rtl/gcd_pkg.sv
// Shared definitions for the GCD sequencer and the FIFOs around it.
package gcd_pkg;

    localparam int DATA_W = 16;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_A,
        S_CAP_A,
        S_RD_B,
        S_CAP_B,
        S_CALC,
        S_WRITE
    } gcd_seq_state_t;

endpackage

// File: rtl/gcd_core.sv
// Subtraction-based GCD datapath: operand registers, compare/subtract step, done/zero decode.
module gcd_core
    import gcd_pkg::*;
#(
    parameter int WIDTH = DATA_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_a,
    input  logic             load_b,
    input  logic             step,
    input  logic [WIDTH-1:0] data_in,
    output logic             done,
    output logic             zero,
    output logic [WIDTH-1:0] result
);

    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;

    // Termination decode in priority order; only meaningful while the sequencer is calculating.
    always_comb begin
        done   = 1'b0;
        zero   = 1'b0;
        result = '0;
        if (a == '0 && b == '0) begin
            done = 1'b1;
            zero = 1'b1;
        end else if (a == '0) begin
            done   = 1'b1;
            result = b;
        end else if (b == '0) begin
            done   = 1'b1;
            result = a;
        end else if (a == b) begin
            done   = 1'b1;
            result = a;
        end
    end

    // The larger operand is always the minuend, so the subtraction never wraps.
    always_ff @(posedge clk) begin
        if (reset) begin
            a <= '0;
            b <= '0;
        end else if (load_a) begin
            a <= data_in;
        end else if (load_b) begin
            b <= data_in;
        end else if (step && !done) begin
            if (a > b) begin
                a <= a - b;
            end else begin
                b <= b - a;
            end
        end
    end

endmodule

// File: rtl/gcd_fifo_sequencer.sv
// Drains operand pairs from the input FIFO, runs the GCD core, and pushes each result to the output FIFO.
module gcd_fifo_sequencer
    import gcd_pkg::*;
#(
    parameter int WIDTH = DATA_W,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             in_empty,
    output logic             in_rd,
    input  logic [WIDTH-1:0] in_data,
    input  logic             out_full,
    output logic             out_wr,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             zero_err,
    output logic [CNT_W-1:0] job_cnt
);

    gcd_seq_state_t state;
    gcd_seq_state_t next_state;

    logic             core_done;
    logic             core_zero;
    logic [WIDTH-1:0] core_result;

    gcd_core #(.WIDTH(WIDTH)) core (
        .clk     (clk),
        .reset   (reset),
        .load_a  (state == S_CAP_A),
        .load_b  (state == S_CAP_B),
        .step    (state == S_CALC),
        .data_in (in_data),
        .done    (core_done),
        .zero    (core_zero),
        .result  (core_result)
    );

    // FIFO strobes are combinational so a read or write lands in the same cycle the flag allows it.
    always_comb begin
        next_state = state;
        in_rd      = 1'b0;
        out_wr     = 1'b0;
        case (state)
            S_IDLE:  if (enable && !in_empty) next_state = S_RD_A;
            S_RD_A: begin
                in_rd = !in_empty;
                if (!in_empty) next_state = S_CAP_A;
            end
            S_CAP_A: next_state = S_RD_B;
            S_RD_B: begin
                in_rd = !in_empty;
                if (!in_empty) next_state = S_CAP_B;
            end
            S_CAP_B: next_state = S_CALC;
            S_CALC:  if (core_done) next_state = S_WRITE;
            S_WRITE: begin
                out_wr = !out_full;
                if (!out_full) next_state = (enable && !in_empty) ? S_RD_A : S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= S_IDLE;
            out_data <= '0;
            zero_err <= 1'b0;
            job_cnt  <= '0;
        end else begin
            state <= next_state;
            if (state == S_CALC && core_done) begin
                out_data <= core_result;
                if (core_zero) zero_err <= 1'b1;
            end
            if (out_wr) job_cnt <= job_cnt + 1'b1;
        end
    end

    assign busy = (state != S_IDLE);

endmodule
